in_frame_sequencer: RTL and testbench
=====================================

IN_FRAME_SEQUENCER -- requirements
Module: in_frame_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, meaning width of one stream word.
REQ-002 SHALL have parameter PPS_WORDS, default 4, meaning stream words per PPS; must be at least 1.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 4, meaning flush pulse length; must be at least 1.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning idle-cycle limit inside a frame.
REQ-005 SHALL have a single clock and an asynchronous, active-high reset; no other clock exists.
REQ-006 clk  in  1  the only clock.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 in_data  in  DATA_WIDTH  word from the input sync buffer.
REQ-009 in_valid / in_sof / in_eof / in_data_is_pps  in  1 each  word qualifiers; no backpressure exists.
REQ-010 flush_req  in  1  host request to abort and resynchronise.
REQ-011 flush  out  1  flush to the input sync buffer.
REQ-012 pps_data  out  PPS_WORDS*DATA_WIDTH  captured PPS; word 0 sits in the LSBs.
REQ-013 pps_valid  out  1  one-cycle pulse when a PPS is complete.
REQ-014 out_data / out_valid / out_sof / out_eof  out  DATA_WIDTH/1/1/1  forwarded frame words.
REQ-015 frame_done  out  1  one-cycle pulse on the last word of a frame.
REQ-016 frame_words  out  32  word count of the last completed frame.
REQ-017 err  out  1  one-cycle error pulse.
REQ-018 err_code  out  2  error cause, held until the next err pulse.

Function
REQ-019 The block SHALL implement the states IDLE, PPS, WAIT_SOF, FRAME and FLUSH.
REQ-020 All outputs SHALL be registered, with 1-cycle latency from an input word to its effect.
REQ-021 In IDLE, a valid PPS word SHALL be stored at PPS index 0 (index goes to 1) and move to PPS; valid non-PPS words SHALL be dropped silently.
REQ-022 In PPS, a valid PPS word SHALL be stored at the current index and the index incremented.
REQ-023 In PPS, storing index PPS_WORDS-1 SHALL pulse pps_valid and move to WAIT_SOF; with PPS_WORDS=1 this happens on the IDLE capture.
REQ-024 In PPS, a valid non-PPS word SHALL cause error code 1 (PPS truncated).
REQ-025 In WAIT_SOF, a valid PPS word SHALL restart PPS capture at index 0 and keep pps_data until complete.
REQ-026 In WAIT_SOF, a word with sof SHALL be forwarded with out_sof, set the count to 1 and move to FRAME.
REQ-027 In WAIT_SOF, a valid word without sof SHALL cause error code 2 (framing).
REQ-028 A word with both sof and eof SHALL be forwarded, pulse frame_done with frame_words=1 and stay in WAIT_SOF.
REQ-029 In FRAME, valid words SHALL be forwarded and counted; the count saturates at 2^32-1.
REQ-030 In FRAME, an eof word SHALL pulse frame_done, load frame_words with the final count and move to WAIT_SOF.
REQ-031 In FRAME, a sof word or a PPS word SHALL cause error code 2 and SHALL NOT be forwarded.
REQ-032 An error SHALL pulse err, update err_code, drop the offending word and enter FLUSH.
REQ-033 In FLUSH, flush SHALL be held high for exactly FLUSH_CYCLES cycles, then the block SHALL go to IDLE; input words during FLUSH are ignored.
REQ-034 flush_req in any state SHALL enter FLUSH with no err pulse, and SHALL win over a simultaneous valid word.
REQ-035 flush_req while already in FLUSH SHALL restart the flush count.
REQ-036 pps_data SHALL keep the last complete PPS across errors and flushes; only reset clears it.

Reset
REQ-037 While rst is high: state IDLE, PPS index 0, all counters 0, and every output 0 (including pps_data, frame_words and err_code).
REQ-038 Reset mid-frame or mid-flush SHALL abort immediately; the block does not drive flush on reset.

Configuration
REQ-039 Macro IN_FRAME_SEQUENCER_TIMEOUT_EN defined: in FRAME, TIMEOUT_CYCLES consecutive cycles without in_valid SHALL cause error code 3 (timeout); the idle counter clears on every valid word.
REQ-040 Macro not defined: no timeout counter exists, and FRAME waits indefinitely.

Verification
REQ-041 PPS_WORDS=4: 4 PPS words then a 3-word frame (sof, mid, eof) -> pps_valid once, 3 forwarded words, frame_done with frame_words=3, err never asserted.
REQ-042 PPS words 0-1, then a non-PPS word -> err with err_code=1, flush high for 4 cycles, then IDLE, and pps_data still 0.
REQ-043 Mid-frame word with sof -> err_code=2, that word not forwarded, flush pulse of 4 cycles, and a next PPS+frame decodes correctly.
REQ-044 Single word with sof and eof in WAIT_SOF -> frame_done with frame_words=1, state WAIT_SOF, and a next sof frame is accepted.
REQ-045 flush_req in the same cycle as a valid eof word -> no frame_done, no err, flush for 4 cycles.
REQ-046 With TIMEOUT_EN and TIMEOUT_CYCLES=16: sof, then 16 idle cycles -> err_code=3; without the macro, same stimulus -> no err.

Source files
------------

// File: rtl/in_frame_sequencer.sv
// Frame sequencer: captures a multi-word PPS, then forwards sof..eof frames, flushing the input buffer on errors.
// Optional idle timeout inside a frame is enabled by defining IN_FRAME_SEQUENCER_TIMEOUT_EN.
module in_frame_sequencer #(
    parameter int DATA_WIDTH     = 256,
    parameter int PPS_WORDS      = 4,
    parameter int FLUSH_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_valid,
    input  logic                              in_sof,
    input  logic                              in_eof,
    input  logic                              in_data_is_pps,
    input  logic                              flush_req,
    output logic                              flush,
    output logic [PPS_WORDS*DATA_WIDTH-1:0]   pps_data,
    output logic                              pps_valid,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    output logic                              out_sof,
    output logic                              out_eof,
    output logic                              frame_done,
    output logic [31:0]                       frame_words,
    output logic                              err,
    output logic [1:0]                        err_code
);
    localparam int IW = (PPS_WORDS > 1) ? $clog2(PPS_WORDS) : 1;
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    if (PPS_WORDS < 1 || FLUSH_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("in_frame_sequencer: PPS_WORDS, FLUSH_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_PPS, S_WAIT_SOF, S_FRAME, S_FLUSH} state_t;

    state_t                                 state;
    logic [IW-1:0]                          pps_idx;
    logic [FW-1:0]                          flush_cnt;
    logic [31:0]                            word_cnt;
    logic [31:0]                            cnt_inc;
    logic [PPS_WORDS-1:0][DATA_WIDTH-1:0]   pps_stage;
    logic [PPS_WORDS-1:0][DATA_WIDTH-1:0]   pps_next;
    logic                                   is_pps;
    logic                                   pps_last;
    logic                                   bad_word;
    logic [1:0]                             bad_code;

`ifdef IN_FRAME_SEQUENCER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;
`endif

    assign is_pps   = in_valid & in_data_is_pps;
    assign pps_last = (pps_idx == IW'(PPS_WORDS - 1));
    assign cnt_inc  = (word_cnt == 32'hFFFF_FFFF) ? word_cnt : word_cnt + 32'd1;

    // Partial captures live in pps_stage so pps_data only ever changes to a complete PPS.
    always_comb begin
        pps_next          = pps_stage;
        pps_next[pps_idx] = in_data;
    end

    always_comb begin
        bad_word = 1'b0;
        bad_code = 2'd0;
        case (state)
            S_PPS: if (in_valid && !in_data_is_pps) begin
                bad_word = 1'b1;
                bad_code = 2'd1;
            end
            S_WAIT_SOF: if (in_valid && !in_data_is_pps && !in_sof) begin
                bad_word = 1'b1;
                bad_code = 2'd2;
            end
            S_FRAME: begin
                if (in_valid && (in_sof || in_data_is_pps)) begin
                    bad_word = 1'b1;
                    bad_code = 2'd2;
                end
`ifdef IN_FRAME_SEQUENCER_TIMEOUT_EN
                else if (!in_valid && idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    bad_word = 1'b1;
                    bad_code = 2'd3;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pps_idx     <= '0;
            flush_cnt   <= '0;
            word_cnt    <= '0;
            pps_stage   <= '0;
            flush       <= 1'b0;
            pps_data    <= '0;
            pps_valid   <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_sof     <= 1'b0;
            out_eof     <= 1'b0;
            frame_done  <= 1'b0;
            frame_words <= '0;
            err         <= 1'b0;
            err_code    <= '0;
`ifdef IN_FRAME_SEQUENCER_TIMEOUT_EN
            idle_cnt    <= '0;
`endif
        end else begin
            pps_valid  <= 1'b0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            // A host flush beats both errors and any word on the same cycle.
            if (flush_req || bad_word) begin
                if (!flush_req) begin
                    err      <= 1'b1;
                    err_code <= bad_code;
                end
                state     <= S_FLUSH;
                flush     <= 1'b1;
                flush_cnt <= FW'(FLUSH_CYCLES - 1);
                pps_idx   <= '0;
            end else begin
                case (state)
                    S_IDLE, S_PPS, S_WAIT_SOF: begin
                        if (is_pps) begin
                            pps_stage[pps_idx] <= in_data;
                            if (pps_last) begin
                                pps_data  <= pps_next;
                                pps_valid <= 1'b1;
                                pps_idx   <= '0;
                                state     <= S_WAIT_SOF;
                            end else begin
                                pps_idx <= pps_idx + IW'(1);
                                state   <= S_PPS;
                            end
                        end else if (state == S_WAIT_SOF && in_valid && in_sof) begin
                            out_data  <= in_data;
                            out_valid <= 1'b1;
                            out_sof   <= 1'b1;
                            out_eof   <= in_eof;
                            if (in_eof) begin
                                frame_done  <= 1'b1;
                                frame_words <= 32'd1;
                            end else begin
                                word_cnt <= 32'd1;
                                state    <= S_FRAME;
`ifdef IN_FRAME_SEQUENCER_TIMEOUT_EN
                                idle_cnt <= '0;
`endif
                            end
                        end
                    end
                    S_FRAME: begin
                        if (in_valid) begin
                            out_data  <= in_data;
                            out_valid <= 1'b1;
                            out_eof   <= in_eof;
                            word_cnt  <= cnt_inc;
`ifdef IN_FRAME_SEQUENCER_TIMEOUT_EN
                            idle_cnt  <= '0;
`endif
                            if (in_eof) begin
                                frame_done  <= 1'b1;
                                frame_words <= cnt_inc;
                                state       <= S_WAIT_SOF;
                            end
                        end
`ifdef IN_FRAME_SEQUENCER_TIMEOUT_EN
                        else begin
                            idle_cnt <= idle_cnt + TW'(1);
                        end
`endif
                    end
                    S_FLUSH: begin
                        if (flush_cnt == '0) begin
                            flush <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            flush_cnt <= flush_cnt - FW'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_in_frame_sequencer.sv
// Randomized bench for in_frame_sequencer against a queue-based model of the PPS/frame rules.
module tb_in_frame_sequencer;
    localparam int DW = 16;
    localparam int PW = 4;
    localparam int FC = 4;
    localparam int TC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DW-1:0]    in_data = '0;
    logic             in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, in_data_is_pps = 1'b0;
    logic             flush_req = 1'b0;
    logic             flush, pps_valid, out_valid, out_sof, out_eof, frame_done, err;
    logic [PW*DW-1:0] pps_data;
    logic [DW-1:0]    out_data;
    logic [31:0]      frame_words;
    logic [1:0]       err_code;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    in_frame_sequencer #(
        .DATA_WIDTH(DW), .PPS_WORDS(PW), .FLUSH_CYCLES(FC), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
        .in_eof(in_eof), .in_data_is_pps(in_data_is_pps), .flush_req(flush_req),
        .flush(flush), .pps_data(pps_data), .pps_valid(pps_valid), .out_data(out_data),
        .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .frame_done(frame_done),
        .frame_words(frame_words), .err(err), .err_code(err_code)
    );

    // Model: counters and a capture queue instead of explicit states.
    int              m_flush_left;
    bit              m_synced, m_in_frame;
    logic [DW-1:0]   m_cap[$];
    int unsigned     m_fcount;
    int              m_idle;
    logic            e_flush, e_pps_valid, e_out_valid, e_out_sof, e_out_eof, e_frame_done, e_err;
    logic [PW*DW-1:0] e_pps_data;
    logic [DW-1:0]   e_out_data;
    logic [31:0]     e_frame_words;
    logic [1:0]      e_err_code;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_flush_left = 0; m_synced = 0; m_in_frame = 0; m_cap.delete(); m_fcount = 0; m_idle = 0;
        e_flush = 0; e_pps_valid = 0; e_out_valid = 0; e_out_sof = 0; e_out_eof = 0;
        e_frame_done = 0; e_err = 0; e_pps_data = '0; e_out_data = '0; e_frame_words = '0;
        e_err_code = '0;
    endtask

    task automatic m_enter_flush();
        m_flush_left = FC; e_flush = 1; m_synced = 0; m_in_frame = 0; m_cap.delete();
    endtask

    task automatic m_error(logic [1:0] code);
        e_err = 1; e_err_code = code; m_enter_flush();
    endtask

    task automatic m_forward();
        e_out_valid = 1; e_out_data = in_data; e_out_sof = in_sof; e_out_eof = in_eof;
    endtask

    task automatic m_step();
        e_pps_valid = 0; e_out_valid = 0; e_out_sof = 0; e_out_eof = 0; e_frame_done = 0; e_err = 0;
        if (flush_req) m_enter_flush();
        else if (m_flush_left > 0) begin
            m_flush_left--;
            if (m_flush_left == 0) e_flush = 0;
        end else if (in_valid) begin
            if (m_in_frame) begin
                if (in_sof || in_data_is_pps) m_error(2'd2);
                else begin
                    m_forward();
                    m_idle = 0;
                    if (m_fcount != 32'hFFFF_FFFF) m_fcount++;
                    if (in_eof) begin
                        e_frame_done = 1; e_frame_words = m_fcount; m_in_frame = 0;
                    end
                end
            end else if (m_cap.size() > 0 && !in_data_is_pps) m_error(2'd1);
            else if (in_data_is_pps) begin
                m_cap.push_back(in_data);
                if (m_cap.size() == PW) begin
                    for (int i = 0; i < PW; i++) e_pps_data[i*DW +: DW] = m_cap[i];
                    e_pps_valid = 1; m_cap.delete(); m_synced = 1;
                end
            end else if (m_synced) begin
                if (!in_sof) m_error(2'd2);
                else begin
                    m_forward();
                    if (in_eof) begin
                        e_frame_done = 1; e_frame_words = 1;
                    end else begin
                        m_in_frame = 1; m_fcount = 1; m_idle = 0;
                    end
                end
            end
        end
`ifdef IN_FRAME_SEQUENCER_TIMEOUT_EN
        else if (m_in_frame) begin
            m_idle++;
            if (m_idle == TC) m_error(2'd3);
        end
`endif
    endtask

    task automatic check_all();
        chk("flush", flush, e_flush);
        chk("pps_valid", pps_valid, e_pps_valid);
        chk("pps_data", pps_data, e_pps_data);
        chk("out_valid", out_valid, e_out_valid);
        if (e_out_valid) chk("out_data", out_data, e_out_data);
        chk("out_sof", out_sof, e_out_sof);
        chk("out_eof", out_eof, e_out_eof);
        chk("frame_done", frame_done, e_frame_done);
        chk("frame_words", frame_words, e_frame_words);
        chk("err", err, e_err);
        chk("err_code", err_code, e_err_code);
    endtask

    // Called at a negedge; applies one cycle of input and checks the registered result.
    task automatic tick(bit v, bit s, bit e, bit p, logic [DW-1:0] d, bit fr);
        in_valid = v; in_sof = s; in_eof = e; in_data_is_pps = p; in_data = d; flush_req = fr;
        m_step();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), DW'($urandom), 1'b0);
    endtask

    task automatic word(bit p, bit s, bit e);
        tick(1'b1, s, e, p, DW'($urandom), 1'b0);
    endtask

    task automatic send_pps(int n);
        for (int i = 0; i < n; i++) word(1'b1, 1'b0, 1'b0);
    endtask

    int r, nf, len;
    bit s, e, fr;

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // Truncated PPS: pps_data must stay at its reset value.
        send_pps(2);
        word(1'b0, 1'b0, 1'b0);
        idle(FC + 2);
        chk("pps_kept_zero", pps_data, '0);

        // Clean PPS and a 3-word frame.
        send_pps(PW);
        word(1'b0, 1'b1, 1'b0); word(1'b0, 1'b0, 1'b0); word(1'b0, 1'b0, 1'b1);
        chk("frame3_words", frame_words, 32'd3);

        // sof inside a frame, then recovery.
        word(1'b0, 1'b1, 1'b0); word(1'b0, 1'b0, 1'b0); word(1'b0, 1'b1, 1'b0);
        idle(FC + 2);
        send_pps(PW);
        word(1'b0, 1'b1, 1'b0); word(1'b0, 1'b0, 1'b1);

        // Single-word frame, then a normal frame.
        word(1'b0, 1'b1, 1'b1);
        word(1'b0, 1'b1, 1'b0); word(1'b0, 1'b0, 1'b0); word(1'b0, 1'b0, 1'b0); word(1'b0, 1'b0, 1'b1);

        // flush_req against an eof word.
        word(1'b0, 1'b1, 1'b0); word(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, DW'($urandom), 1'b1);
        idle(2);
        tick(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);   // restart mid-flush
        idle(FC + 2);

        // Idle gap inside a frame.
        send_pps(PW);
        word(1'b0, 1'b1, 1'b0);
        idle(TC + 1);
        idle(FC + 2);

        // Asynchronous reset mid-frame.
        send_pps(PW);
        word(1'b0, 1'b1, 1'b0); word(1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        m_reset();
        check_all();
        @(negedge clk);
        in_valid = 1'b0; flush_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int ep = 0; ep < 400; ep++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), DW'($urandom), 1'b1);
                idle($urandom_range(0, FC + 1));
            end else if (r == 1) begin
                send_pps($urandom_range(1, PW - 1));
                word(1'b0, 1'($urandom), 1'b0);
                idle($urandom_range(0, FC + 1));
            end else begin
                if ($urandom_range(0, 2) != 0) send_pps(PW);
                nf = $urandom_range(1, 3);
                for (int f = 0; f < nf; f++) begin
                    len = $urandom_range(1, 6);
                    for (int k = 0; k < len; k++) begin
                        s  = (k == 0) || ($urandom_range(0, 19) == 0);
                        e  = (k == len - 1);
                        fr = ($urandom_range(0, 49) == 0);
                        tick(1'b1, s, e, ($urandom_range(0, 29) == 0), DW'($urandom), fr);
                        idle($urandom_range(0, 2));
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
